traffic_control_param: RTL and testbench

Parametrised two-approach intersection controller: the next generation of `traffic_control`. It adds configurable phase durations, an all-red clearance interval, latched pedestrian requests with minimum-green early termination, and a flashing (night/fault) mode. It is a Moore FSM with a single down-counter. It drives replicated lamp buses for the NS and EW approaches plus walk lamps, and sits directly under the lab top level.

---
 rtl/traffic_control_param.sv | 217 +++++++++++++++++++++
 tb/tb_traffic_control_param.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/traffic_control_param.sv
// traffic_control_param
// Two-approach intersection controller with configurable phase durations,
// all-red clearance, latched pedestrian requests with minimum-green early
// termination, and a flashing (night/fault) mode. Moore FSM driven by a
// single down-counter; lamp and walk outputs are registered from the
// next-state value so they change on the same edge as the state.
//
// Ports:
//   clk                               rising-edge clock
//   rst_a                             synchronous active-high reset
//   ped_req_ns / ped_req_ew           pedestrian requests (level or pulse)
//   flash_en                          request flashing mode
//   green_/yellow_/red_ns [LANES]     NS lamp buses (all bits equal)
//   green_/yellow_/red_ew [LANES]     EW lamp buses (all bits equal)
//   walk_ns / walk_ew                 walk lamps
//   state_o [3]                       current state encoding
module traffic_control_param #(
  parameter int LANES     = 3,
  parameter int GREEN_T   = 20,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int MIN_GREEN = 8,
  parameter int FLASH_T   = 5,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             ped_req_ns,
  input  logic             ped_req_ew,
  input  logic             flash_en,
  output logic [LANES-1:0] green_ns,
  output logic [LANES-1:0] yellow_ns,
  output logic [LANES-1:0] red_ns,
  output logic [LANES-1:0] green_ew,
  output logic [LANES-1:0] yellow_ew,
  output logic [LANES-1:0] red_ew,
  output logic             walk_ns,
  output logic             walk_ew,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_2  = 3'd5,
    FLASH     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);
  // Counter value at which MIN_GREEN cycles of green have elapsed.
  localparam logic [CNT_W-1:0] EARLY_LIM = CNT_W'(GREEN_T - MIN_GREEN);

  // Lamp decode, bit order {g_ns, y_ns, r_ns, g_ew, y_ew, r_ew}.
  function automatic logic [5:0] lamp_decode(input state_t s, input logic blink_bit);
    case (s)
      NS_GREEN:  lamp_decode = 6'b100_001;
      NS_YELLOW: lamp_decode = 6'b010_001;
      ALLRED_1:  lamp_decode = 6'b001_001;
      EW_GREEN:  lamp_decode = 6'b001_100;
      EW_YELLOW: lamp_decode = 6'b001_010;
      ALLRED_2:  lamp_decode = 6'b001_001;
      FLASH:     lamp_decode = {1'b0, blink_bit, 1'b0, 1'b0, 1'b0, blink_bit};
      default:   lamp_decode = 6'b001_001;
    endcase
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             blink, blink_n;
  logic             ped_ns_pend, ped_ns_pend_n;
  logic             ped_ew_pend, ped_ew_pend_n;
  logic             walk_ns_n, walk_ew_n;
  logic [5:0]       lamps;
  logic             ped_ns_any, ped_ew_any;

  // A request in the current cycle counts as pending immediately.
  assign ped_ns_any = ped_ns_pend | ped_req_ns;
  assign ped_ew_any = ped_ew_pend | ped_req_ew;

  // Next-state, counter, latch and walk logic.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt - ONE;
    blink_n       = blink;
    walk_ns_n     = walk_ns;
    walk_ew_n     = walk_ew;
    ped_ns_pend_n = ped_ns_any;
    ped_ew_pend_n = ped_ew_any;
    case (state)
      NS_GREEN: begin
        if (flash_en || (cnt == ZERO) || (ped_ew_any && (cnt <= EARLY_LIM))) begin
          state_n   = NS_YELLOW;
          cnt_n     = YELLOW_LD;
          walk_ns_n = 1'b0;
        end else begin
          state_n = NS_GREEN;
        end
      end
      NS_YELLOW: begin
        if (cnt == ZERO) begin
          state_n = ALLRED_1;
          cnt_n   = ALLRED_LD;
        end else begin
          state_n = NS_YELLOW;
        end
      end
      ALLRED_1: begin
        if (cnt == ZERO) begin
          if (flash_en) begin
            state_n = FLASH;
            cnt_n   = FLASH_LD;
            blink_n = 1'b1;
          end else begin
            state_n       = EW_GREEN;
            cnt_n         = GREEN_LD;
            walk_ew_n     = ped_ew_any;
            ped_ew_pend_n = 1'b0;
          end
        end else begin
          state_n = ALLRED_1;
        end
      end
      EW_GREEN: begin
        if (flash_en || (cnt == ZERO) || (ped_ns_any && (cnt <= EARLY_LIM))) begin
          state_n   = EW_YELLOW;
          cnt_n     = YELLOW_LD;
          walk_ew_n = 1'b0;
        end else begin
          state_n = EW_GREEN;
        end
      end
      EW_YELLOW: begin
        if (cnt == ZERO) begin
          state_n = ALLRED_2;
          cnt_n   = ALLRED_LD;
        end else begin
          state_n = EW_YELLOW;
        end
      end
      ALLRED_2: begin
        if (cnt == ZERO) begin
          if (flash_en) begin
            state_n = FLASH;
            cnt_n   = FLASH_LD;
            blink_n = 1'b1;
          end else begin
            state_n       = NS_GREEN;
            cnt_n         = GREEN_LD;
            walk_ns_n     = ped_ns_any;
            ped_ns_pend_n = 1'b0;
          end
        end else begin
          state_n = ALLRED_2;
        end
      end
      FLASH: begin
        // The counter doubles as the blink half-period timer here.
        if (!flash_en) begin
          state_n = ALLRED_2;
          cnt_n   = ALLRED_LD;
        end else if (cnt == ZERO) begin
          blink_n = ~blink;
          cnt_n   = FLASH_LD;
        end else begin
          state_n = FLASH;
        end
      end
      default: begin
        state_n   = ALLRED_2;
        cnt_n     = ALLRED_LD;
        blink_n   = 1'b1;
        walk_ns_n = 1'b0;
        walk_ew_n = 1'b0;
      end
    endcase
  end

  // State, counter, latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      state       <= ALLRED_2;
      cnt         <= ALLRED_LD;
      blink       <= 1'b1;
      ped_ns_pend <= 1'b0;
      ped_ew_pend <= 1'b0;
      walk_ns     <= 1'b0;
      walk_ew     <= 1'b0;
      lamps       <= 6'b001_001;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      blink       <= blink_n;
      ped_ns_pend <= ped_ns_pend_n;
      ped_ew_pend <= ped_ew_pend_n;
      walk_ns     <= walk_ns_n;
      walk_ew     <= walk_ew_n;
      lamps       <= lamp_decode(state_n, blink_n);
    end
  end

  assign green_ns  = {LANES{lamps[5]}};
  assign yellow_ns = {LANES{lamps[4]}};
  assign red_ns    = {LANES{lamps[3]}};
  assign green_ew  = {LANES{lamps[2]}};
  assign yellow_ew = {LANES{lamps[1]}};
  assign red_ew    = {LANES{lamps[0]}};
  assign state_o   = state;

endmodule

// File: tb/tb_traffic_control_param.sv
// Scoreboard bench for traffic_control_param with default parameters.
// The stimulus process walks directed phases, pushing the expected state,
// lamps and walk values for every cycle; a negedge monitor pops and compares.
module tb_traffic_control_param;

  localparam int LANES = 3;
  localparam logic [2:0] NSG = 3'd0, NSY = 3'd1, AR1 = 3'd2, EWG = 3'd3,
                         EWY = 3'd4, AR2 = 3'd5, FL = 3'd6;

  logic             clk = 1'b0;
  logic             rst_a = 1'b1;
  logic             ped_req_ns = 1'b0;
  logic             ped_req_ew = 1'b0;
  logic             flash_en = 1'b0;
  logic [LANES-1:0] green_ns, yellow_ns, red_ns, green_ew, yellow_ew, red_ew;
  logic             walk_ns, walk_ew;
  logic [2:0]       state_o;

  typedef struct packed {
    logic [2:0] st;
    logic       bl;
    logic       wns;
    logic       wew;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   cyc = 0;

  traffic_control_param dut (
    .clk(clk), .rst_a(rst_a),
    .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew), .flash_en(flash_en),
    .green_ns(green_ns), .yellow_ns(yellow_ns), .red_ns(red_ns),
    .green_ew(green_ew), .yellow_ew(yellow_ew), .red_ew(red_ew),
    .walk_ns(walk_ns), .walk_ew(walk_ew), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Expected lamp buses {g_ns,y_ns,r_ns,g_ew,y_ew,r_ew}, each LANES wide.
  function automatic logic [6*LANES-1:0] exp_lamps(input logic [2:0] st, input logic bl);
    logic [5:0] b;
    case (st)
      NSG:     b = 6'b100_001;
      NSY:     b = 6'b010_001;
      AR1:     b = 6'b001_001;
      AR2:     b = 6'b001_001;
      EWG:     b = 6'b001_100;
      EWY:     b = 6'b001_010;
      FL:      b = {1'b0, bl, 4'b0000} | {5'b00000, bl};
      default: b = 6'b000_000;
    endcase
    return {{LANES{b[5]}}, {LANES{b[4]}}, {LANES{b[3]}},
            {LANES{b[2]}}, {LANES{b[1]}}, {LANES{b[0]}}};
  endfunction

  // One phase of n cycles; *_at give the 1-based cycle of a one-cycle pulse
  // (0 = none); flash_en is high from cycle fl_from on (0 = never).
  task automatic phase(input logic [2:0] st, input int n, input logic wns, input logic wew,
                       input logic bl, input int ns_at, input int ew_at,
                       input int fl_from, input int rst_at);
    exp_t e;
    for (int i = 1; i <= n; i++) begin
      e.st = st; e.bl = bl; e.wns = wns; e.wew = wew;
      sb.push_back(e);
      ped_req_ns = (i == ns_at);
      ped_req_ew = (i == ew_at);
      flash_en   = (fl_from != 0) && (i >= fl_from);
      rst_a      = (i == rst_at);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ph(input logic [2:0] st, input int n);
    phase(st, n, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard once per cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk_cnt++;
      if (state_o === mon_e.st &&
          {green_ns, yellow_ns, red_ns, green_ew, yellow_ew, red_ew} === exp_lamps(mon_e.st, mon_e.bl) &&
          walk_ns === mon_e.wns && walk_ew === mon_e.wew) begin
        pass_cnt++;
      end else begin
        $display("FAIL cycle_%0d: got state=%0d lamps=%h walk=%b%b, want state=%0d lamps=%h walk=%b%b",
                 cyc, state_o, {green_ns, yellow_ns, red_ns, green_ew, yellow_ew, red_ew},
                 walk_ns, walk_ew, mon_e.st, exp_lamps(mon_e.st, mon_e.bl), mon_e.wns, mon_e.wew);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    // Reset release: default 52-cycle period, then start of the next.
    ph(AR2, 2); ph(NSG, 20); ph(NSY, 4); ph(AR1, 2); ph(EWG, 20); ph(EWY, 4); ph(AR2, 2);
    // EW request pulse in cycle 3 of NS green: green cut to MIN_GREEN.
    phase(NSG, 8, 1'b0, 1'b0, 1'b1, 0, 3, 0, 0);
    ph(NSY, 4); ph(AR1, 2);
    phase(EWG, 20, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
    ph(EWY, 4); ph(AR2, 2);
    // EW request in cycle 15 (past MIN_GREEN): exit at once.
    phase(NSG, 15, 1'b0, 1'b0, 1'b1, 0, 15, 0, 0);
    ph(NSY, 4); ph(AR1, 2);
    phase(EWG, 20, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
    ph(EWY, 4);
    // NS request held across the ALLRED_2 -> NS_GREEN edge.
    phase(AR2, 2, 1'b0, 1'b0, 1'b1, 2, 0, 0, 0);
    phase(NSG, 20, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0);
    ph(NSY, 4); ph(AR1, 2);
    // The re-latched NS request shortens EW green and is walked next time.
    ph(EWG, 8); ph(EWY, 4); ph(AR2, 2);
    phase(NSG, 20, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
    ph(NSY, 4); ph(AR1, 2); ph(EWG, 20); ph(EWY, 4); ph(AR2, 2);
    // Flash request in cycle 5 of EW green.
    ph(NSG, 20); ph(NSY, 4); ph(AR1, 2);
    phase(EWG, 5, 1'b0, 1'b0, 1'b1, 0, 0, 5, 0);
    phase(EWY, 4, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0);
    phase(AR2, 2, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0);
    phase(FL, 5, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0);
    phase(FL, 5, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0);
    phase(FL, 1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    ph(AR2, 2); ph(NSG, 20);
    // EW request during NS yellow, then reset: latch must be cleared.
    phase(NSY, 2, 1'b0, 1'b0, 1'b1, 0, 1, 0, 2);
    ph(AR2, 2); ph(NSG, 20); ph(NSY, 4); ph(AR1, 2); ph(EWG, 20); ph(EWY, 4); ph(AR2, 2);
    @(negedge clk);
    #1;
    chk_cnt++;
    if (sb.size() == 0) begin
      pass_cnt++;
    end else begin
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
